// File: rtl/zigzag_rom_loader.sv
// zigzag_rom_loader: decodes HPS download bytes into program / graphics /
// colour-PROM write strobes, arbitrates the shared ROM address bus between
// the loader and the running CPU, and holds the game core in reset until a
// complete image is resident and a settle period has elapsed.
module zigzag_rom_loader #(
  parameter logic [15:0] PROG_END      = 16'h4000,
  parameter logic [15:0] GFX_END       = 16'h5000,
  parameter logic [15:0] PROM_END      = 16'h5020,
  parameter int          SETTLE_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic [15:0] cpu_addr,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        prog_we,
  output logic        gfx_we,
  output logic        prom_we,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES - 1);
  localparam logic [16:0] IMAGE_SIZE  = {1'b0, PROM_END};
  localparam logic [16:0] CNT_MAX     = 17'h1FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t      state_q, state_d;
  logic        dl_q;
  logic        dl_rise, dl_fall;
  logic        enter_load, settle_start, set_err;

  logic        wr_q;
  logic        prog_we_q, gfx_we_q, prom_we_q;
  logic [7:0]  rom_data_q;
  logic [15:0] ld_addr_q, ld_addr_d;

  logic [16:0] cnt_q;
  logic        ovr_q;
  logic [15:0] settle_q;
  logic        err_q;

  logic        accept;
  logic        in_prog, in_gfx, in_prom;
  logic        complete;

  assign dl_rise  = dn_download & ~dl_q;
  assign dl_fall  = ~dn_download & dl_q;

  // Writes are only taken while the window is open and the FSM is loading;
  // a strobe coinciding with the falling edge of dn_download is dropped.
  assign accept   = (state_q == S_LOAD) & dn_wr & dn_download;

  assign in_prog  = dn_addr < PROG_END;
  assign in_gfx   = dn_addr < GFX_END;
  assign in_prom  = dn_addr < PROM_END;

  assign complete = (cnt_q >= IMAGE_SIZE) & ~ovr_q;

  // Region-relative address for the decoded write
  always_comb begin
    ld_addr_d = dn_addr;
    if (in_prog)      ld_addr_d = dn_addr;
    else if (in_gfx)  ld_addr_d = dn_addr - PROG_END;
    else if (in_prom) ld_addr_d = dn_addr - GFX_END;
  end

  // Download-window edge detector; tracks the input even in reset so a
  // window still open when reset releases is not mistaken for a new one
  always_ff @(posedge clk_sys) begin
    dl_q <= dn_download;
  end

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state and per-transition control pulses
  always_comb begin
    state_d      = state_q;
    enter_load   = 1'b0;
    settle_start = 1'b0;
    set_err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dl_rise) begin
          state_d    = S_LOAD;
          enter_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (dl_fall) begin
          state_d      = S_SETTLE;
          settle_start = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == 16'd0) begin
          if (complete) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
            set_err = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (dl_rise) begin
          state_d    = S_LOAD;
          enter_load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered write decode: one strobe, address and data the cycle after dn_wr
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q       <= 1'b0;
      prog_we_q  <= 1'b0;
      gfx_we_q   <= 1'b0;
      prom_we_q  <= 1'b0;
      rom_data_q <= 8'h00;
      ld_addr_q  <= 16'h0000;
    end else begin
      wr_q      <= accept;
      prog_we_q <= accept & in_prog;
      gfx_we_q  <= accept & ~in_prog & in_gfx;
      prom_we_q <= accept & ~in_gfx & in_prom;
      if (accept) begin
        rom_data_q <= dn_data;
        ld_addr_q  <= ld_addr_d;
      end
    end
  end

  // Saturating count of in-image writes plus overrun flag, cleared per download
  always_ff @(posedge clk_sys) begin
    if (reset || enter_load) begin
      cnt_q <= 17'd0;
      ovr_q <= 1'b0;
    end else if (accept) begin
      if (in_prom) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 17'd1;
      end else begin
        ovr_q <= 1'b1;
      end
    end
  end

  // Settle down-counter, loaded as the download window closes
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      settle_q <= 16'd0;
    end else if (settle_start) begin
      settle_q <= SETTLE_INIT;
    end else if (state_q == S_SETTLE && settle_q != 16'd0) begin
      settle_q <= settle_q - 16'd1;
    end
  end

  // Sticky error flag: set when settle ends on a bad image, cleared on a new load
  always_ff @(posedge clk_sys) begin
    if (reset || enter_load) err_q <= 1'b0;
    else if (set_err)        err_q <= 1'b1;
  end

  // The loader owns the bus through LOAD and for the cycle carrying the last
  // strobe; core_reset is high in both cases, so the CPU never sees it.
  assign rom_addr   = (state_q == S_LOAD || wr_q) ? ld_addr_q : cpu_addr;
  assign rom_data   = rom_data_q;
  assign prog_we    = prog_we_q;
  assign gfx_we     = gfx_we_q;
  assign prom_we    = prom_we_q;
  assign core_reset = (state_q != S_RUN);
  assign load_done  = (state_q == S_RUN);
  assign load_error = err_q;

endmodule

// File: tb/tb_zigzag_rom_loader.sv
// Bench for zigzag_rom_loader: drives full, short, overrun and interrupted
// downloads with random data, gaps and CPU addresses, checking every strobe
// against the address-region rules and each download outcome against the
// image-completeness rule.
module tb_zigzag_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        dn_download = 1'b0;
  logic        dn_wr = 1'b0;
  logic [15:0] dn_addr = 16'h0;
  logic [7:0]  dn_data = 8'h0;
  logic [15:0] cpu_addr = 16'h0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        prog_we, gfx_we, prom_we;
  logic        core_reset, load_done, load_error;

  int checks = 0;
  int failures = 0;
  int n_prog, n_gfx, n_prom;
  int tb_good;
  bit tb_ovr;

  zigzag_rom_loader dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .dn_download(dn_download),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .cpu_addr   (cpu_addr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .prog_we    (prog_we),
    .gfx_we     (gfx_we),
    .prom_we    (prom_we),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 20) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_we"}, 32'({prog_we, gfx_we, prom_we}), 32'd0);
  endtask

  // One download cycle; w=0 is a gap. Expected strobe follows from the region rules.
  task automatic wr_byte(input logic [15:0] a, input bit w);
    logic [7:0] d;
    d = 8'($urandom);
    dn_addr = a;
    dn_data = d;
    dn_wr = w;
    tick();
    chk("prog_we", 32'(prog_we), 32'(w && a < 16'h4000));
    chk("gfx_we",  32'(gfx_we),  32'(w && a >= 16'h4000 && a < 16'h5000));
    chk("prom_we", 32'(prom_we), 32'(w && a >= 16'h5000 && a < 16'h5020));
    if (w) begin
      chk("rom_data", 32'(rom_data), 32'(d));
      if (a < 16'h4000)      chk("rom_addr_prog", 32'(rom_addr), 32'(a));
      else if (a < 16'h5000) chk("rom_addr_gfx",  32'(rom_addr), 32'(a - 16'h4000));
      else if (a < 16'h5020) chk("rom_addr_prom", 32'(rom_addr), 32'(a - 16'h5000));
      if (a < 16'h5020) tb_good++;
      else              tb_ovr = 1'b1;
    end
    n_prog += 32'(prog_we);
    n_gfx  += 32'(gfx_we);
    n_prom += 32'(prom_we);
    dn_wr = 1'b0;
  endtask

  task automatic start_dl();
    tb_good = 0;
    tb_ovr = 1'b0;
    n_prog = 0; n_gfx = 0; n_prom = 0;
    dn_wr = 1'b0;
    dn_download = 1'b1;
    tick();
    chk("start_core_reset", 32'(core_reset), 32'd1);
    chk("start_load_done", 32'(load_done), 32'd0);
    chk("start_load_error", 32'(load_error), 32'd0);
  endtask

  task automatic end_dl();
    bit ok;
    ok = (tb_good >= 32'h5020) && !tb_ovr;
    dn_wr = 1'b0;
    dn_download = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cpu_addr = 16'($urandom);
      #1;
      chk("settle_rom_addr", 32'(rom_addr), 32'(cpu_addr));
      chk_quiet("settle");
      chk("settle_core_reset", 32'(core_reset), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("end_core_reset", 32'(core_reset), 32'(!ok));
      chk("end_load_done", 32'(load_done), 32'(ok));
      chk("end_load_error", 32'(load_error), 32'(!ok));
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values
    reset = 1'b1;
    repeat (3) tick();
    cpu_addr = 16'hBEEF;
    #1;
    chk("rst_we", 32'({prog_we, gfx_we, prom_we}), 32'd0);
    chk("rst_rom_data", 32'(rom_data), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'hBEEF);
    reset = 1'b0;
    tick();

    // dn_wr without the download window in IDLE
    for (int i = 0; i < 4; i++) begin
      dn_addr = 16'($urandom_range(0, 16'h501F));
      dn_wr = 1'b1;
      tick();
      chk_quiet("idle_ign");
      chk("idle_ign_core_reset", 32'(core_reset), 32'd1);
      chk("idle_ign_load_done", 32'(load_done), 32'd0);
    end
    dn_wr = 1'b0;
    repeat (2) tick();
    chk("idle_no_load", 32'(core_reset), 32'd1);

    // full download, a strobe every cycle
    start_dl();
    for (int a = 0; a < 32'h5020; a++) wr_byte(16'(a), 1'b1);
    chk("full_n_prog", 32'(n_prog), 32'h4000);
    chk("full_n_gfx",  32'(n_gfx),  32'h1000);
    chk("full_n_prom", 32'(n_prom), 32'h20);
    end_dl();

    // RUN: combinational CPU passthrough and ignored stray dn_wr
    cpu_addr = 16'h1234;
    #1;
    chk("run_rom_addr_1234", 32'(rom_addr), 32'h1234);
    chk_quiet("run");
    for (int i = 0; i < 4; i++) begin
      dn_addr = 16'($urandom_range(0, 16'h501F));
      dn_wr = 1'b1;
      tick();
      cpu_addr = 16'($urandom);
      #1;
      chk_quiet("run_ign");
      chk("run_ign_rom_addr", 32'(rom_addr), 32'(cpu_addr));
      chk("run_ign_load_done", 32'(load_done), 32'd1);
      chk("run_ign_core_reset", 32'(core_reset), 32'd0);
    end
    dn_wr = 1'b0;

    // re-download from RUN with one byte past the image: overrun error
    start_dl();
    for (int a = 0; a <= 32'h5020; a++) wr_byte(16'(a), 1'b1);
    chk("ovr_n_prom", 32'(n_prom), 32'h20);
    end_dl();

    // short download: error and core stays in reset
    start_dl();
    for (int a = 32'h4F00; a < 32'h5000; a++) wr_byte(16'(a), 1'b1);
    end_dl();

    // reset in the middle of a download
    start_dl();
    for (int i = 0; i < 100; i++) wr_byte(16'($urandom_range(0, 16'h501F)), 1'b1);
    dn_addr = 16'h0010;
    dn_wr = 1'b1;
    reset = 1'b1;
    tick();
    chk_quiet("midrst");
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    chk("midrst_load_done", 32'(load_done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("postrst");
      chk("postrst_core_reset", 32'(core_reset), 32'd1);
    end
    dn_wr = 1'b0;
    dn_download = 1'b0;
    tick();

    // full download with random gaps after the interrupted one
    start_dl();
    begin
      int a;
      a = 0;
      while (a < 32'h5020) begin
        if ($urandom_range(0, 7) == 0) wr_byte(16'(a), 1'b0);
        else begin
          wr_byte(16'(a), 1'b1);
          a++;
        end
      end
    end
    chk("gap_n_prog", 32'(n_prog), 32'h4000);
    chk("gap_n_gfx",  32'(n_gfx),  32'h1000);
    chk("gap_n_prom", 32'(n_prom), 32'h20);
    end_dl();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
